// File: rtl/new_usb_ohci_pkg.sv
// Shared OHCI scheduling types: channel kinds, scheduler states and the CBSR width.
package new_usb_ohci_pkg;

  localparam int CbsrWidth = 2;

  typedef enum logic [1:0] {
    CH_CONTROL   = 2'd0,
    CH_BULK      = 2'd1,
    CH_INTERRUPT = 2'd2
  } channel_t;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_NP_SEL     = 3'd1,
    ST_NP_WAIT    = 3'd2,
    ST_P_WAIT     = 3'd3,
    ST_FRAME_DONE = 3'd4
  } sched_state_t;

endpackage

// File: rtl/new_usb_cb_ratio_counter.sv
// Counts served control TDs and flags when the control:bulk ratio forces a bulk turn.
// The count clears on the same control TD that raises force_bulk_o.
module new_usb_cb_ratio_counter
  import new_usb_ohci_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 ctrl_served_i,
  input  logic [CbsrWidth-1:0] cbsr_i,
  output logic                 force_bulk_o
);

  logic [CbsrWidth-1:0] count_q, count_d;

  // >= rather than == so a CBSR lowered below the running count still wraps.
  assign force_bulk_o = ctrl_served_i && (count_q >= cbsr_i);

  always_comb begin
    count_d = count_q;
    if (ctrl_served_i) begin
      count_d = force_bulk_o ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule

// File: rtl/new_usb_list_scheduler.sv
// Frame-level OHCI list scheduler: one list-service request at a time, control:bulk ratio, np2p/p2np pulses.
// NEW_USB_LIST_SCHEDULER_STATS_EN adds saturating served-TD and overrun counters.
module new_usb_list_scheduler
  import new_usb_ohci_pkg::*;
#(
  parameter int StatsWidth = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cle_i,
  input  logic                 ble_i,
  input  logic                 ple_i,
  input  logic                 clf_i,
  input  logic                 blf_i,
  input  logic [CbsrWidth-1:0] cbsr_i,
  input  logic                 sof_i,
  input  logic                 periodic_start_i,
  input  logic                 frame_end_i,
  input  logic                 served_td_i,
  input  logic                 list_end_i,
  output logic                 req_valid_o,
  output channel_t             req_type_o,
  output logic                 req_head_o,
  input  logic                 req_ready_i,
  output logic                 clf_clear_o,
  output logic                 blf_clear_o,
  output logic                 context_switch_np2p_o,
  output logic                 context_switch_p2np_o,
  output logic                 overrun_o
`ifdef NEW_USB_LIST_SCHEDULER_STATS_EN
  ,
  output logic [StatsWidth-1:0] stat_ctrl_td_o,
  output logic [StatsWidth-1:0] stat_bulk_td_o,
  output logic [StatsWidth-1:0] stat_per_td_o,
  output logic [StatsWidth-1:0] stat_overrun_o
`endif
);

  sched_state_t state_q, state_d;
  channel_t     cur_type_q, cur_type_d;
  channel_t     np_type_q, np_type_d;
  channel_t     lock_type_q, lock_type_d;
  logic         ctrl_head_q, ctrl_head_d;
  logic         bulk_head_q, bulk_head_d;
  logic         ctrl_srv_q, ctrl_srv_d;
  logic         bulk_srv_q, bulk_srv_d;
  logic         lock_q, lock_d;
  logic         per_pend_q, per_pend_d;
  logic         per_head_q, per_head_d;
  logic         clf_clr_q, clf_clr_d;
  logic         blf_clr_q, blf_clr_d;
  logic         np2p_q, np2p_d;
  logic         p2np_q, p2np_d;
  logic         ovr_q, ovr_d;

  logic ctrl_avail, bulk_avail, sel_ctrl, sel_bulk;
  logic ctrl_served, bulk_served, per_served;
  logic force_bulk, enter_per, handshake;

  assign ctrl_avail  = cle_i && clf_i;
  assign bulk_avail  = ble_i && blf_i;
  assign sel_ctrl    = ctrl_avail && ((np_type_q == CH_CONTROL) || !bulk_avail);
  assign sel_bulk    = !sel_ctrl && bulk_avail;
  assign ctrl_served = served_td_i && (cur_type_q == CH_CONTROL);
  assign bulk_served = served_td_i && (cur_type_q == CH_BULK);
  assign per_served  = served_td_i && (cur_type_q == CH_INTERRUPT);
  assign handshake   = (state_q == ST_NP_SEL) && req_valid_o && req_ready_i;

  new_usb_cb_ratio_counter u_ratio (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .ctrl_served_i (ctrl_served),
    .cbsr_i        (cbsr_i),
    .force_bulk_o  (force_bulk)
  );

  // Once presented, a nonperiodic request is locked so it cannot change before acceptance.
  always_comb begin
    req_valid_o = 1'b0;
    req_type_o  = CH_CONTROL;
    req_head_o  = 1'b0;
    case (state_q)
      ST_NP_SEL: begin
        if (lock_q) begin
          req_valid_o = 1'b1;
          req_type_o  = lock_type_q;
        end else if (sel_ctrl || sel_bulk) begin
          req_valid_o = 1'b1;
          req_type_o  = sel_ctrl ? CH_CONTROL : CH_BULK;
        end
        req_head_o = req_valid_o &&
                     ((req_type_o == CH_CONTROL) ? ctrl_head_q : bulk_head_q);
      end
      ST_P_WAIT: begin
        req_valid_o = per_pend_q;
        req_type_o  = per_pend_q ? CH_INTERRUPT : CH_CONTROL;
        req_head_o  = per_pend_q && per_head_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cur_type_d  = cur_type_q;
    np_type_d   = np_type_q;
    lock_type_d = lock_type_q;
    ctrl_head_d = ctrl_head_q;
    bulk_head_d = bulk_head_q;
    ctrl_srv_d  = ctrl_srv_q;
    bulk_srv_d  = bulk_srv_q;
    lock_d      = lock_q;
    per_pend_d  = per_pend_q;
    per_head_d  = per_head_q;
    clf_clr_d   = 1'b0;
    blf_clr_d   = 1'b0;
    np2p_d      = 1'b0;
    p2np_d      = 1'b0;
    ovr_d       = 1'b0;
    enter_per   = 1'b0;

    // List bookkeeping follows the last accepted request even after it was dropped.
    if (ctrl_served) begin
      ctrl_head_d = 1'b0;
      ctrl_srv_d  = 1'b1;
      if (force_bulk) np_type_d = CH_BULK;
    end
    if (bulk_served) begin
      bulk_head_d = 1'b0;
      bulk_srv_d  = 1'b1;
      np_type_d   = CH_CONTROL;
    end
    if (list_end_i && (cur_type_q == CH_CONTROL)) begin
      ctrl_head_d = 1'b1;
      clf_clr_d   = !(ctrl_srv_q || served_td_i);
      ctrl_srv_d  = 1'b0;
    end
    if (list_end_i && (cur_type_q == CH_BULK)) begin
      bulk_head_d = 1'b1;
      blf_clr_d   = !(bulk_srv_q || served_td_i);
      bulk_srv_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (sof_i) state_d = ST_NP_SEL;
      end
      ST_NP_SEL: begin
        if (handshake) begin
          cur_type_d = req_type_o;
          lock_d     = 1'b0;
          state_d    = ST_NP_WAIT;
        end else if (req_valid_o) begin
          lock_d      = 1'b1;
          lock_type_d = req_type_o;
        end else if (periodic_start_i) begin
          enter_per = 1'b1;
        end
      end
      ST_NP_WAIT: begin
        if (served_td_i || list_end_i) begin
          if (periodic_start_i) enter_per = 1'b1;
          else                  state_d   = ST_NP_SEL;
        end
      end
      ST_P_WAIT: begin
        if (per_pend_q && req_ready_i) per_pend_d = 1'b0;
        if (list_end_i) begin
          p2np_d     = 1'b1;
          per_pend_d = 1'b0;
          state_d    = ST_FRAME_DONE;
        end else if (served_td_i) begin
          per_pend_d = 1'b1;
          per_head_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (enter_per) begin
      if (ple_i) begin
        state_d    = ST_P_WAIT;
        np2p_d     = 1'b1;
        per_pend_d = 1'b1;
        per_head_d = 1'b1;
        cur_type_d = CH_INTERRUPT;
      end else begin
        state_d = ST_FRAME_DONE;
      end
    end

    // Frame end wins over everything in flight; a same-cycle SOF then starts the new frame.
    if (frame_end_i) begin
      ovr_d      = (state_q == ST_P_WAIT);
      p2np_d     = 1'b0;
      np2p_d     = 1'b0;
      lock_d     = 1'b0;
      per_pend_d = 1'b0;
      state_d    = sof_i ? ST_NP_SEL : ST_IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      cur_type_q  <= CH_CONTROL;
      np_type_q   <= CH_CONTROL;
      lock_type_q <= CH_CONTROL;
      ctrl_head_q <= 1'b1;
      bulk_head_q <= 1'b1;
      ctrl_srv_q  <= 1'b0;
      bulk_srv_q  <= 1'b0;
      lock_q      <= 1'b0;
      per_pend_q  <= 1'b0;
      per_head_q  <= 1'b1;
      clf_clr_q   <= 1'b0;
      blf_clr_q   <= 1'b0;
      np2p_q      <= 1'b0;
      p2np_q      <= 1'b0;
      ovr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_type_q  <= cur_type_d;
      np_type_q   <= np_type_d;
      lock_type_q <= lock_type_d;
      ctrl_head_q <= ctrl_head_d;
      bulk_head_q <= bulk_head_d;
      ctrl_srv_q  <= ctrl_srv_d;
      bulk_srv_q  <= bulk_srv_d;
      lock_q      <= lock_d;
      per_pend_q  <= per_pend_d;
      per_head_q  <= per_head_d;
      clf_clr_q   <= clf_clr_d;
      blf_clr_q   <= blf_clr_d;
      np2p_q      <= np2p_d;
      p2np_q      <= p2np_d;
      ovr_q       <= ovr_d;
    end
  end

  assign clf_clear_o           = clf_clr_q;
  assign blf_clear_o           = blf_clr_q;
  assign context_switch_np2p_o = np2p_q;
  assign context_switch_p2np_o = p2np_q;
  assign overrun_o             = ovr_q;

`ifdef NEW_USB_LIST_SCHEDULER_STATS_EN
  logic [StatsWidth-1:0] st_ctrl_q, st_bulk_q, st_per_q, st_ovr_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      st_ctrl_q <= '0;
      st_bulk_q <= '0;
      st_per_q  <= '0;
      st_ovr_q  <= '0;
    end else begin
      if (ctrl_served && !(&st_ctrl_q)) st_ctrl_q <= st_ctrl_q + 1'b1;
      if (bulk_served && !(&st_bulk_q)) st_bulk_q <= st_bulk_q + 1'b1;
      if (per_served  && !(&st_per_q))  st_per_q  <= st_per_q + 1'b1;
      if (ovr_q       && !(&st_ovr_q))  st_ovr_q  <= st_ovr_q + 1'b1;
    end
  end

  assign stat_ctrl_td_o = st_ctrl_q;
  assign stat_bulk_td_o = st_bulk_q;
  assign stat_per_td_o  = st_per_q;
  assign stat_overrun_o = st_ovr_q;
`else
  logic [StatsWidth-1:0] unused_stats;
  logic                  unused_per_served;
  assign unused_stats      = '0;
  assign unused_per_served = per_served;
`endif

endmodule
